sha_output_ctrl: RTL and testbench

- Sequencing controller for the 8-word serial-to-parallel digest shift register on the SHA output path.
- Accepts 32-bit hash words from the SHA core over a valid/ready handshake and drives the register's shift_enable.
- Counts words until a full 256-bit digest is assembled, compares the digest against the mining target, and presents the result over a valid/ready handshake to the nonce/control logic.
- Applies backpressure to the SHA core while a digest is pending.

---
 rtl/sha_out_pkg.sv | 14 +
 rtl/sha_target_cmp.sv | 14 +
 rtl/sha_output_ctrl.sv | 85 ++++++++
 tb/tb_sha_output_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha_out_pkg.sv
// Shared types and sizes for the SHA output-path sequencing logic.
package sha_out_pkg;

    localparam int unsigned DIGEST_W = 256;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned NWORDS   = 8;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CHECK   = 2'd1,
        PRESENT = 2'd2
    } state_e;

endpackage

// File: rtl/sha_target_cmp.sv
// Unsigned less-or-equal comparator between an assembled digest and the mining target.
module sha_target_cmp
    import sha_out_pkg::*;
#(
    parameter int unsigned W = DIGEST_W
) (
    input  logic [W-1:0] digest,
    input  logic [W-1:0] target,
    output logic         le
);

    assign le = (digest <= target);

endmodule

// File: rtl/sha_output_ctrl.sv
// Sequences word transfers into the digest shift register, checks the digest
// against the target and presents the hit flag over a valid/ready handshake.
module sha_output_ctrl #(
    parameter int unsigned NWORDS = 8,
    parameter int unsigned WORD_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     word_valid,
    output logic                     word_ready,
    output logic                     shift_enable,
    input  logic [NWORDS*WORD_W-1:0] digest_in,
    input  logic [NWORDS*WORD_W-1:0] target,
    output logic                     digest_valid,
    input  logic                     digest_ready,
    output logic                     hit,
    output logic [2:0]               word_count,
    output logic                     busy
);

    import sha_out_pkg::*;

    localparam logic [1:0] ST_COLLECT = COLLECT;
    localparam logic [1:0] ST_CHECK   = CHECK;
    localparam logic [1:0] ST_PRESENT = PRESENT;
    localparam logic [2:0] LAST_WORD  = 3'(NWORDS - 1);

    logic [1:0] state;
    logic       le;
    logic       xfer;

    sha_target_cmp #(
        .W(NWORDS * WORD_W)
    ) u_cmp (
        .digest(digest_in),
        .target(target),
        .le    (le)
    );

    // Gating with rst keeps the strobe quiet while reset is held.
    assign word_ready   = (state == ST_COLLECT) && !rst;
    assign xfer         = word_valid && word_ready && !clear;
    assign shift_enable = xfer;
    assign digest_valid = (state == ST_PRESENT);
    assign busy         = (word_count != '0) || (state != ST_COLLECT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_COLLECT;
            word_count <= '0;
            hit        <= 1'b0;
        end else if (clear) begin
            state      <= ST_COLLECT;
            word_count <= '0;
            hit        <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (xfer) begin
                        if (word_count == LAST_WORD) begin
                            word_count <= '0;
                            state      <= ST_CHECK;
                        end else begin
                            word_count <= word_count + 3'd1;
                        end
                    end
                end
                ST_CHECK: begin
                    hit   <= le;
                    state <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (digest_ready) begin
                        state <= ST_COLLECT;
                    end
                end
                default: begin
                    state <= ST_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha_output_ctrl.sv
// Self-checking bench for sha_output_ctrl with a bench-side shift register and hit scoreboard.
module tb_sha_output_ctrl;

    logic         clk;
    logic         rst;
    logic         clear;
    logic         word_valid;
    logic         word_ready;
    logic         shift_enable;
    logic [255:0] digest_in;
    logic [255:0] target;
    logic         digest_valid;
    logic         digest_ready;
    logic         hit;
    logic [2:0]   word_count;
    logic         busy;

    logic [31:0]  hash_word;
    logic [255:0] sr;
    logic         exp_q[$];
    int unsigned  n_checks = 0;
    int unsigned  n_fail   = 0;
    int unsigned  pulses   = 0;
    int unsigned  exp_shifts = 0;
    int unsigned  exp_count  = 0;

    sha_output_ctrl #(
        .NWORDS(8),
        .WORD_W(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .shift_enable(shift_enable),
        .digest_in   (digest_in),
        .target      (target),
        .digest_valid(digest_valid),
        .digest_ready(digest_ready),
        .hit         (hit),
        .word_count  (word_count),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external serial-to-parallel register.
    always @(posedge clk) begin
        if (shift_enable) begin
            sr <= {sr[223:0], hash_word};
            pulses <= pulses + 1;
        end
    end
    assign digest_in = sr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int unsigned gap);
        int unsigned n;
        n = 0;
        hash_word  = w;
        word_valid = 1'b1;
        #1;
        while (!word_ready && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (!word_ready) begin
            check("word_timeout", 64'd0, 64'd1);
            word_valid = 1'b0;
        end else begin
            check("shift_en", shift_enable, 1);
            exp_shifts++;
            exp_count = (exp_count + 1) % 8;
            @(negedge clk);
            word_valid = 1'b0;
            #1;
            check("word_count", word_count, exp_count);
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic send_digest(input logic [255:0] d, input int unsigned gap);
        logic [31:0] w;
        for (int i = 0; i < 8; i++) begin
            w = d[255 - 32*i -: 32];
            send_word(w, (i == 7) ? 0 : gap);
        end
        exp_q.push_back(d <= target);
        check("ready_in_check", word_ready, 0);
        check("valid_in_check", digest_valid, 0);
        check("busy_in_check", busy, 1);
        @(negedge clk); #1;
        check("latency_valid", digest_valid, 1);
    endtask

    task automatic receive(input int unsigned hold);
        logic h0;
        logic e;
        h0 = hit;
        hash_word  = 32'hDEAD_BEEF;
        word_valid = 1'b1;
        repeat (hold) begin
            @(negedge clk); #1;
            check("hold_shift", shift_enable, 0);
            check("hold_valid", digest_valid, 1);
            check("hold_hit", hit, h0);
        end
        if (exp_q.size() == 0) begin
            check("sb_empty", 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check("hit", hit, e);
        end
        digest_ready = 1'b1;
        check("hs_shift", shift_enable, 0);
        @(negedge clk);
        digest_ready = 1'b0;
        #1;
        check("valid_drop", digest_valid, 0);
        check("ready_back", word_ready, 1);
        word_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d1;
        logic         dropped;
        rst = 1'b1; clear = 1'b0; word_valid = 1'b1; digest_ready = 1'b0;
        hash_word = '0; sr = '0;
        target = {16'h0000, {240{1'b1}}};
        for (int i = 0; i < 8; i++) d1[255 - 32*i -: 32] = 32'(i);

        @(negedge clk);
        check("rst_shift", shift_enable, 0);
        check("rst_valid", digest_valid, 0);
        check("rst_hit", hit, 0);
        check("rst_count", word_count, 0);
        rst = 1'b0;
        word_valid = 1'b0;
        #1;
        check("rst_ready", word_ready, 1);
        check("rst_busy", busy, 0);

        // Back-to-back words with a 5-cycle consumer stall.
        send_digest(d1, 0);
        receive(5);

        send_digest(256'd1, 0);
        receive(0);
        send_digest(target, 0);
        receive(1);
        send_digest(target + 256'd1, 0);
        receive(0);

        // clear alongside a word transfer after three words
        for (int i = 0; i < 3; i++) send_word(32'(i + 16), 0);
        hash_word = 32'h1234_5678;
        word_valid = 1'b1;
        clear = 1'b1;
        #1;
        check("clr_shift", shift_enable, 0);
        @(negedge clk);
        clear = 1'b0;
        word_valid = 1'b0;
        #1;
        exp_count = 0;
        check("clr_count", word_count, 0);
        check("clr_busy", busy, 0);
        send_digest(256'd1, 0);
        receive(0);

        // clear beats a simultaneous digest_ready
        send_digest(d1, 0);
        digest_ready = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        digest_ready = 1'b0;
        #1;
        check("clrp_valid", digest_valid, 0);
        check("clrp_hit", hit, 0);
        check("clrp_busy", busy, 0);
        dropped = exp_q.pop_front();

        // asynchronous reset while presenting a hit
        send_digest(target, 0);
        check("pre_rst_hit", hit, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", digest_valid, 0);
        check("arst_hit", hit, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_ready", word_ready, 1);
        check("arst_count", word_count, 0);
        dropped = exp_q.pop_front();
        exp_count = 0;

        // Sparse arrivals: one word every three cycles.
        send_digest({8{32'hA5A5_5A5A}}, 2);
        receive(1);

        check("pulses", pulses, exp_shifts);
        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
